// File: rtl/led_show_pkg.sv
// Shared types and constants for the dual-bank LED show sequencer.
package led_show_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RAMP = 2'd2
  } phase_t;

  localparam int         PWM_W   = 8;
  localparam logic [7:0] LED_ON  = 8'hFF;
  localparam logic [7:0] LED_OFF = 8'h00;

endpackage

// File: rtl/led_pwm_engine.sv
// Shared PWM engine: one free-running 8-bit counter compared against two duty
// levels. Bank outputs are registered, so they lag duty/pwm_cnt by one cycle.
module led_pwm_engine
  import led_show_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] duty0,
  input  logic [PWM_W-1:0] duty1,
  output logic [7:0]       LED0,
  output logic [7:0]       LED1
);

  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [7:0]       led0_q, led0_d;
  logic [7:0]       led1_q, led1_d;

  // Counter wraps naturally 255->0; strict compare keeps duty 0 fully dark.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    led0_d    = (pwm_cnt_q < duty0) ? LED_ON : LED_OFF;
    led1_d    = (pwm_cnt_q < duty1) ? LED_ON : LED_OFF;
  end

  // Counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      led0_q    <= LED_OFF;
      led1_q    <= LED_OFF;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      led0_q    <= led0_d;
      led1_q    <= led1_d;
    end
  end

  assign LED0 = led0_q;
  assign LED1 = led1_q;

endmodule

// File: rtl/led_show_sequencer.sv
// Dual-bank light show: hold one bank bright / one dim, cross-fade, swap, repeat.
// Owns the step tick, the IDLE/HOLD/RAMP sequencer and the shared PWM engine.
// Optional feature: define LED_SEQ_PAUSE_EN to make the pause input freeze the
// sequence (PWM keeps running); otherwise pause is ignored.
module led_show_sequencer
  import led_show_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int STEP_HZ    = 100,
  parameter int DUTY_HI    = 230,
  parameter int DUTY_LO    = 13,
  parameter int FADE_STEP  = 4,
  parameter int HOLD_TICKS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pause,
  output logic [7:0] LED0,
  output logic [7:0] LED1,
  output logic [1:0] phase,
  output logic       dir
);

  localparam int TICK_PER = CLK_HZ / STEP_HZ;
  localparam int TICK_W   = (TICK_PER > 1) ? $clog2(TICK_PER) : 1;
  localparam int HOLD_W   = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PER - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [PWM_W-1:0]  HI8       = PWM_W'(DUTY_HI);
  localparam logic [PWM_W-1:0]  LO8       = PWM_W'(DUTY_LO);
  localparam logic [PWM_W-1:0]  STEP8     = PWM_W'(FADE_STEP);
  localparam logic [8:0]        HI9       = 9'(DUTY_HI);
  localparam logic [8:0]        LO9       = 9'(DUTY_LO);
  localparam logic [8:0]        STEP9     = 9'(FADE_STEP);

  phase_t            phase_q, phase_d;
  logic              dir_q, dir_d;
  logic [PWM_W-1:0]  duty0_q, duty0_d;
  logic [PWM_W-1:0]  duty1_q, duty1_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic              tick;
  logic              freeze;
  logic [PWM_W-1:0]  bright, dim, bright_n, dim_n;
  logic [8:0]        bright_sum;

`ifdef LED_SEQ_PAUSE_EN
  assign freeze = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign freeze       = 1'b0;
`endif

  // Tick fires on the terminal count; the counter sits at 0 while IDLE.
  assign tick = (phase_q != IDLE) && (tick_cnt_q == TICK_LAST);

  // Cross-fade arithmetic in 9 bits so neither direction can wrap.
  always_comb begin
    bright     = dir_q ? duty1_q : duty0_q;
    dim        = dir_q ? duty0_q : duty1_q;
    bright_sum = {1'b0, bright} + STEP9;
    bright_n   = (bright_sum >= HI9) ? HI8 : bright_sum[PWM_W-1:0];
    dim_n      = ({1'b0, dim} >= (LO9 + STEP9)) ? (dim - STEP8) : LO8;
  end

  // Sequencer next-state: disable beats everything, then pause, then phase logic.
  always_comb begin
    phase_d    = phase_q;
    dir_d      = dir_q;
    duty0_d    = duty0_q;
    duty1_d    = duty1_q;
    tick_cnt_d = tick_cnt_q;
    hold_cnt_d = hold_cnt_q;
    if (!enable) begin
      phase_d    = IDLE;
      dir_d      = 1'b0;
      duty0_d    = '0;
      duty1_d    = '0;
      tick_cnt_d = '0;
      hold_cnt_d = '0;
    end else if (!freeze) begin
      if (phase_q != IDLE)
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
      case (phase_q)
        IDLE: begin
          phase_d    = HOLD;
          dir_d      = 1'b0;
          duty0_d    = HI8;
          duty1_d    = LO8;
          tick_cnt_d = '0;
          hold_cnt_d = '0;
        end
        HOLD: begin
          if (tick) begin
            if (hold_cnt_q == HOLD_LAST) begin
              phase_d    = RAMP;
              dir_d      = ~dir_q;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
        end
        RAMP: begin
          if (tick) begin
            duty0_d = dir_q ? dim_n : bright_n;
            duty1_d = dir_q ? bright_n : dim_n;
            if (bright_n == HI8 && dim_n == LO8)
              phase_d = HOLD;
          end
        end
        default: phase_d = IDLE;
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= IDLE;
      dir_q      <= 1'b0;
      duty0_q    <= '0;
      duty1_q    <= '0;
      tick_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      phase_q    <= phase_d;
      dir_q      <= dir_d;
      duty0_q    <= duty0_d;
      duty1_q    <= duty1_d;
      tick_cnt_q <= tick_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  led_pwm_engine u_pwm (
    .clk   (clk),
    .rst   (rst),
    .duty0 (duty0_q),
    .duty1 (duty1_q),
    .LED0  (LED0),
    .LED1  (LED1)
  );

  assign phase = phase_q;
  assign dir   = dir_q;

endmodule
